// File: rtl/countdown_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : countdown_sequencer
// Brief    : Round-robin sharing of one external loadable down-counter among
//            N_REQ requesters, with tick-paced decrement and completion/abort.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_sequencer #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int PW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] load_val,
    input  logic               tick,
    input  logic               cnt_zero,
    output logic               cnt_latch,
    output logic               cnt_dec,
    output logic [W-1:0]       cnt_in,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               done,
    output logic               abort
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW:0]   c_NREQ = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] c_LAST = PW'(N_REQ - 1);

    logic [1:0]         r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [W-1:0]       r_cnt_in;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic               w_found;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_sel;
    logic [N_REQ-1:0]   w_onehot;
    logic [W-1:0]       w_load_sel;
    logic [PW-1:0]      w_ptr_next;
    logic               w_owner_req;

    // Rotating a doubled copy puts the requester at ptr in bit 0, so the
    // lowest set bit of the rotated vector is the round-robin winner.
    assign w_req_dbl = {req, req};
    assign w_req_rot = N_REQ'(w_req_dbl >> r_ptr);
    assign w_found   = |w_req_rot;

    always_comb begin
        w_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            end
        end
        if (w_sum >= c_NREQ) begin
            w_sel = PW'(w_sum - c_NREQ);
        end else begin
            w_sel = w_sum[PW-1:0];
        end
    end

    always_comb begin
        w_onehot   = '0;
        w_load_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel == PW'(k)) begin
                w_onehot[k] = 1'b1;
                w_load_sel  = load_val[k*W +: W];
            end
        end
    end

    assign w_ptr_next  = (r_owner == c_LAST) ? '0 : r_owner + PW'(1);
    assign w_owner_req = |(req & r_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_cnt_in <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_onehot;
                        r_cnt_in <= w_load_sel;
                        r_owner  <= w_sel;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_COUNT;
                end
                S_COUNT: begin
                    // Reaching zero takes precedence over a simultaneous req drop.
                    if (cnt_zero) begin
                        r_state <= S_DONE;
                    end else if (!w_owner_req) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign cnt_latch = (r_state == S_LOAD);
    assign cnt_dec   = (r_state == S_COUNT) & tick & ~cnt_zero;
    assign cnt_in    = r_cnt_in;
    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign abort     = (r_state == S_COUNT) & ~cnt_zero & ~w_owner_req;

endmodule
`default_nettype wire

// File: tb/tb_countdown_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_countdown_sequencer
// Brief    : Directed self-checking bench with a behavioural 4-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] load_val;
    logic        tick;
    logic        cnt_zero;
    logic        cnt_latch;
    logic        cnt_dec;
    logic [3:0]  cnt_in;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        abort;

    int total = 0;
    int bad   = 0;

    logic [3:0] m_cnt;

    countdown_sequencer #(.N_REQ(4), .W(4), .PW(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .load_val  (load_val),
        .tick      (tick),
        .cnt_zero  (cnt_zero),
        .cnt_latch (cnt_latch),
        .cnt_dec   (cnt_dec),
        .cnt_in    (cnt_in),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_latch)    m_cnt <= cnt_in;
        else if (cnt_dec) m_cnt <= m_cnt - 4'd1;
    end
    assign cnt_zero = (m_cnt == 4'd0);

    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            if (cnt_latch && cnt_dec) begin
                bad++;
                $display("FAIL latch_dec_overlap: latch=%b dec=%b want not both", cnt_latch, cnt_dec);
            end
            if (cnt_dec && m_cnt == 4'd0) begin
                bad++;
                $display("FAIL underflow: dec=%b cnt=%0d want no dec at zero", cnt_dec, m_cnt);
            end
            if (done && grant == 4'd0) begin
                bad++;
                $display("FAIL done_grant: done=%b grant=%b want grant valid", done, grant);
            end
        end
    end

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 4'd0;
        tick  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'b1111;
        load_val = 16'hFFFF;
        tick = 1'b1;
        #1;
        total++;
        if (grant !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0 ||
            cnt_latch !== 1'b0 || cnt_dec !== 1'b0 || cnt_in !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: grant=%b busy=%b done=%b abort=%b latch=%b dec=%b cnt_in=%0d want all 0",
                     grant, busy, done, abort, cnt_latch, cnt_dec, cnt_in);
        end
        do_reset();
    endtask

    task automatic test_single;
        int dec_n = 0, latch_n = 0, done_at = 0;
        load_val = 16'd0;
        load_val[3:0] = 4'd3;
        tick = 1'b1;
        req = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if (grant !== 4'b0001 || cnt_latch !== 1'b1 || cnt_in !== 4'd3) begin
                    bad++;
                    $display("FAIL single_load: grant=%b latch=%b cnt_in=%0d want 0001/1/3", grant, cnt_latch, cnt_in);
                end
            end
            dec_n   += int'(cnt_dec);
            latch_n += int'(cnt_latch);
            if (done === 1'b1) begin
                done_at = n;
                req = 4'd0;
            end
            if (n == 7) begin
                total++;
                if (grant !== 4'd0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL single_release: grant=%b busy=%b want 0000/0", grant, busy);
                end
            end
        end
        total++;
        if (dec_n != 3 || latch_n != 1 || done_at != 6) begin
            bad++;
            $display("FAIL single_counts: dec=%0d latch=%0d done_at=%0d want 3/1/6", dec_n, latch_n, done_at);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [5];
        int exp_c [5];
        logic [3:0] prev = 4'd0;
        int gi = 0, done_n = 0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_c[0] = 1; exp_c[1] = 6; exp_c[2] = 11; exp_c[3] = 16; exp_c[4] = 21;
        do_reset();
        load_val = 16'h1111;
        tick = 1'b1;
        req = 4'b1111;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (grant !== 4'd0 && grant !== prev && gi < 5) begin
                total++;
                if (grant !== exp_g[gi] || n != exp_c[gi]) begin
                    bad++;
                    $display("FAIL rr_grant%0d: grant=%b cycle=%0d want %b at %0d", gi, grant, n, exp_g[gi], exp_c[gi]);
                end
                gi++;
            end
            prev = grant;
            done_n += int'(done);
            if (n == 5) begin
                total++;
                if (busy !== 1'b0 || grant !== 4'd0) begin
                    bad++;
                    $display("FAIL rr_gap: busy=%b grant=%b want 0/0000", busy, grant);
                end
            end
        end
        req = 4'd0;
        total++;
        if (gi != 5 || done_n != 5) begin
            bad++;
            $display("FAIL rr_counts: grants=%0d dones=%0d want 5/5", gi, done_n);
        end
    endtask

    task automatic test_zero_load;
        int dec_n = 0;
        load_val = 16'd0;
        tick = 1'b1;
        req = 4'b0100;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            dec_n += int'(cnt_dec);
            total++;
            case (n)
                1: if (grant !== 4'b0100 || cnt_latch !== 1'b1 || cnt_in !== 4'd0) begin
                       bad++;
                       $display("FAIL zero_load: grant=%b latch=%b cnt_in=%0d want 0100/1/0", grant, cnt_latch, cnt_in);
                   end
                2: if (busy !== 1'b1 || cnt_zero !== 1'b1 || cnt_dec !== 1'b0 || done !== 1'b0) begin
                       bad++;
                       $display("FAIL zero_count: busy=%b zero=%b dec=%b done=%b want 1/1/0/0", busy, cnt_zero, cnt_dec, done);
                   end
                3: begin
                       if (done !== 1'b1 || grant !== 4'b0100) begin
                           bad++;
                           $display("FAIL zero_done: done=%b grant=%b want 1/0100", done, grant);
                       end
                       req = 4'd0;
                   end
                default: if (busy !== 1'b0 || dec_n != 0) begin
                       bad++;
                       $display("FAIL zero_end: busy=%b decs=%0d want 0/0", busy, dec_n);
                   end
            endcase
        end
    endtask

    task automatic test_slow_tick;
        int dec_n = 0, done_at = 0;
        load_val = 16'd0;
        load_val[3:0] = 4'd5;
        tick = 1'b0;
        req = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            tick = (n % 3 == 0);
            #1;
            if (cnt_dec === 1'b1 && tick !== 1'b1) begin
                bad++;
                $display("FAIL slow_dec_tick: dec=%b tick=%b want dec only with tick", cnt_dec, tick);
            end
            dec_n += int'(cnt_dec);
            if (done === 1'b1 && done_at == 0) begin
                done_at = n;
                req = 4'd0;
            end
        end
        tick = 1'b1;
        total++;
        if (dec_n != 5 || done_at != 17) begin
            bad++;
            $display("FAIL slow_counts: decs=%0d done_at=%0d want 5/17", dec_n, done_at);
        end
    endtask

    task automatic test_abort;
        int done_at = 0;
        load_val = 16'd0;
        load_val[7:4] = 4'd4;
        tick = 1'b1;
        req = 4'b0010;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        total++;
        if (grant !== 4'b0010 || cnt_zero !== 1'b0 || m_cnt !== 4'd2) begin
            bad++;
            $display("FAIL abort_pre: grant=%b zero=%b cnt=%0d want 0010/0/2", grant, cnt_zero, m_cnt);
        end
        req = 4'd0;
        #1;
        total++;
        if (abort !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse: abort=%b done=%b want 1/0", abort, done);
        end
        @(negedge clk);
        total++;
        if (grant !== 4'd0 || busy !== 1'b0 || abort !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_after: grant=%b busy=%b abort=%b done=%b want 0000/0/0/0", grant, busy, abort, done);
        end
        load_val[11:8] = 4'd1;
        req = 4'b0110;
        @(negedge clk);
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL abort_ptr: grant=%b want 0100", grant);
        end
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            if (done === 1'b1 && done_at == 0) begin
                done_at = n;
                req = 4'd0;
            end
        end
        total++;
        if (done_at != 4) begin
            bad++;
            $display("FAIL abort_next_done: done_at=%0d want 4", done_at);
        end

        load_val[15:12] = 4'd2;
        req = 4'b1000;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        total++;
        if (cnt_zero !== 1'b1 || grant !== 4'b1000) begin
            bad++;
            $display("FAIL tie_pre: zero=%b grant=%b want 1/1000", cnt_zero, grant);
        end
        req = 4'd0;
        #1;
        total++;
        if (abort !== 1'b0) begin
            bad++;
            $display("FAIL tie_abort: abort=%b want 0", abort);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || grant !== 4'b1000) begin
            bad++;
            $display("FAIL tie_done: done=%b grant=%b want 1/1000", done, grant);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant !== 4'd0) begin
            bad++;
            $display("FAIL tie_end: busy=%b grant=%b want 0/0000", busy, grant);
        end
    endtask

    task automatic test_reset_mid;
        int done_at = 0;
        load_val = 16'd0;
        load_val[3:0] = 4'd6;
        tick = 1'b1;
        req = 4'b0001;
        for (int n = 1; n <= 3; n++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0 ||
            cnt_latch !== 1'b0 || cnt_dec !== 1'b0 || cnt_in !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset: grant=%b busy=%b done=%b abort=%b latch=%b dec=%b cnt_in=%0d want all 0",
                     grant, busy, done, abort, cnt_latch, cnt_dec, cnt_in);
        end
        req = 4'd0;
        #9;
        rst_n = 1'b1;
        @(negedge clk);
        load_val[11:8] = 4'd2;
        req = 4'b0100;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if (grant !== 4'b0100 || cnt_in !== 4'd2 || cnt_latch !== 1'b1) begin
                    bad++;
                    $display("FAIL mid_regrant: grant=%b cnt_in=%0d latch=%b want 0100/2/1", grant, cnt_in, cnt_latch);
                end
            end
            if (done === 1'b1 && done_at == 0) begin
                done_at = n;
                req = 4'd0;
            end
        end
        total++;
        if (done_at != 5) begin
            bad++;
            $display("FAIL mid_done: done_at=%0d want 5", done_at);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_load();
        test_slow_tick();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
